sh_mtu: RTL and testbench

- Parametrised multi-channel timer unit on the SH internal peripheral bus (DBUS side, alongside INTC/DIVU/SCI/FRT/WDT).
- Generalises the fixed FRT/WDT timebase: N channels of configurable width, each with its own prescaler tap from a shared free-running divider.
- Each channel has compare-match, optional auto-reload, overflow detection, and a per-channel interrupt with a programmable vector for INTC.

---
 rtl/sh_mtu.sv | 223 ++++++++++++++++++++++
 tb/tb_sh_mtu.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sh_mtu.sv
// sh_mtu -- multi-channel timer unit for the SH internal peripheral bus.
//
// CH timer channels, each W bits wide.
// All channels share one free-running prescaler counter. Each channel picks
// its own tap from that counter through TCR.PSC.
// A channel can compare-match, optionally auto-reload, and detect overflow.
// It drives a level interrupt to INTC, together with a vector number that
// software programs.
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   CE_R / CE_F         rising / falling phase enables (all state moves on CE_R)
//   RES_N               synchronous chip reset, active-low, sampled on CE_R
//   IBUS_A/DI/DO/BA     address, write data, read data, byte-lane enables
//   IBUS_WE/REQ         write strobe, access request
//   IBUS_BUSY           wait request (never asserted)
//   IBUS_ACT            access falls inside this block's window
//   IRQ[CH-1:0]         per-channel interrupt level
//   VEC[8*CH-1:0]       per-channel vector, channel n at bits 8n+7:8n
//
// Register map per channel (BASE + 16*ch):
//   +0x0 TCNT   +0x4 TCOR   +0x8 TCR   +0xC TSR
//
// The decode window always reserves eight channel slots (BASE .. BASE+0x7F).
// Inside that window, slots at or above CH are acknowledged on IBUS_ACT.
// Those slots read as 0 and ignore writes.

module sh_mtu_ch #(
  parameter int W        = 16,
  parameter int DIV_BITS = 13
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                ce_i,
  input  logic                res_n_i,
  input  logic [DIV_BITS-1:0] div_i,
  input  logic                we_i,
  input  logic [1:0]          reg_i,
  input  logic [3:0]          ba_i,
  input  logic [31:0]         di_i,
  output logic [31:0]         rdata_o,
  output logic                irq_o,
  output logic [7:0]          vec_o
);
  localparam logic [31:0]  TCR_MASK = 32'h00FF_01FF;
  localparam logic [W-1:0] ONES     = '1;

  logic [W-1:0]        tcnt_q, tcnt_d, tcor_q, tcor_d;
  logic [31:0]         tcr_q, tcr_d;
  logic                cmf_q, cmf_d, ovf_q, ovf_d, irq_q, irq_d;
  logic [31:0]         wmask;
  logic [W-1:0]        wmask_w;
  logic [4:0]          psc;
  logic [DIV_BITS-1:0] tick_mask;
  logic                tick, run;

  assign wmask   = {{8{ba_i[3]}}, {8{ba_i[2]}}, {8{ba_i[1]}}, {8{ba_i[0]}}};
  assign wmask_w = wmask[W-1:0];

  // PSC above DIV_BITS saturates to the slowest available tap.
  assign psc = (tcr_q[4:0] > 5'(DIV_BITS)) ? 5'(DIV_BITS) : tcr_q[4:0];

  always_comb begin
    tick_mask = '0;
    for (int k = 0; k < DIV_BITS; k++)
      if (k < int'(psc)) tick_mask[k] = 1'b1;
  end

  // A tick fires when the low PSC bits of the shared divider are all ones.
  assign tick = &(div_i | ~tick_mask);

  always_comb begin
    tcnt_d = tcnt_q;
    tcor_d = tcor_q;
    tcr_d  = tcr_q;
    cmf_d  = cmf_q;
    ovf_d  = ovf_q;
    if (we_i) begin
      case (reg_i)
        2'd1: tcor_d = (tcor_q & ~wmask_w) | (di_i[W-1:0] & wmask_w);
        2'd2: tcr_d  = ((tcr_q & ~wmask) | (di_i & wmask)) & TCR_MASK;
        2'd3: begin
          if (ba_i[0] && di_i[0]) cmf_d = 1'b0;
          if (ba_i[0] && di_i[1]) ovf_d = 1'b0;
        end
        default: ;
      endcase
    end
    // A write that clears STR stops the step in the same cycle.
    // A write that sets STR only counts from the next cycle onward.
    run = tcr_q[5] && tcr_d[5] && tick;
    if (run) begin
      if (tcnt_q == tcor_q) begin
        cmf_d  = 1'b1;
        tcnt_d = tcr_q[6] ? '0 : tcnt_q + 1'b1;
        if (!tcr_q[6] && tcnt_q == ONES) ovf_d = 1'b1;
      end else if (tcnt_q == ONES) begin
        ovf_d  = 1'b1;
        tcnt_d = '0;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
    // A software write to TCNT overrides any increment in the same cycle.
    // Flag sets above are placed after the clears, so a hardware set wins.
    if (we_i && reg_i == 2'd0)
      tcnt_d = (tcnt_q & ~wmask_w) | (di_i[W-1:0] & wmask_w);
  end

  assign irq_d = (cmf_q & tcr_q[7]) | (ovf_q & tcr_q[8]);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tcnt_q <= '0;
      tcor_q <= ONES;
      tcr_q  <= '0;
      cmf_q  <= 1'b0;
      ovf_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else if (ce_i) begin
      if (!res_n_i) begin
        tcnt_q <= '0;
        tcor_q <= ONES;
        tcr_q  <= '0;
        cmf_q  <= 1'b0;
        ovf_q  <= 1'b0;
        irq_q  <= 1'b0;
      end else begin
        tcnt_q <= tcnt_d;
        tcor_q <= tcor_d;
        tcr_q  <= tcr_d;
        cmf_q  <= cmf_d;
        ovf_q  <= ovf_d;
        irq_q  <= irq_d;
      end
    end
  end

  always_comb begin
    case (reg_i)
      2'd0:    rdata_o = 32'(tcnt_q);
      2'd1:    rdata_o = 32'(tcor_q);
      2'd2:    rdata_o = tcr_q;
      default: rdata_o = {30'b0, ovf_q, cmf_q};
    endcase
  end

  assign irq_o = irq_q;
  assign vec_o = tcr_q[23:16];
endmodule

module sh_mtu #(
  parameter int          CH       = 4,
  parameter int          W        = 16,
  parameter int          DIV_BITS = 13,
  parameter logic [31:0] BASE     = 32'hFFFFFC00
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            CE_R,
  input  logic            CE_F,
  input  logic            RES_N,
  input  logic [31:0]     IBUS_A,
  input  logic [31:0]     IBUS_DI,
  output logic [31:0]     IBUS_DO,
  input  logic [3:0]      IBUS_BA,
  input  logic            IBUS_WE,
  input  logic            IBUS_REQ,
  output logic            IBUS_BUSY,
  output logic            IBUS_ACT,
  output logic [CH-1:0]   IRQ,
  output logic [8*CH-1:0] VEC
);
  logic [31:0]          off;
  logic [2:0]           ch_sel;
  logic [1:0]           reg_sel;
  logic [DIV_BITS-1:0]  div_q, div_d;
  logic [CH-1:0][31:0]  rdata;
  logic [CH-1:0][7:0]   vec;
  logic                 unused_ok;

  // CE_F is carried for a future falling-phase use and has no effect today.
  assign unused_ok = &{1'b0, CE_F};

  assign off       = IBUS_A - BASE;
  assign IBUS_ACT  = IBUS_REQ && (off < 32'd128);
  assign ch_sel    = off[6:4];
  assign reg_sel   = off[3:2];
  assign IBUS_BUSY = 1'b0;

  assign div_d = div_q + DIV_BITS'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    div_q <= '0;
    else if (CE_R) div_q <= RES_N ? div_d : '0;
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    sh_mtu_ch #(.W(W), .DIV_BITS(DIV_BITS)) u_ch (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .ce_i    (CE_R),
      .res_n_i (RES_N),
      .div_i   (div_q),
      .we_i    (IBUS_ACT && IBUS_WE && ch_sel == 3'(i)),
      .reg_i   (reg_sel),
      .ba_i    (IBUS_BA),
      .di_i    (IBUS_DI),
      .rdata_o (rdata[i]),
      .irq_o   (IRQ[i]),
      .vec_o   (vec[i])
    );
  end

  assign VEC = vec;

  always_comb begin
    IBUS_DO = '0;
    if (IBUS_ACT && !IBUS_WE)
      for (int i = 0; i < CH; i++)
        if (ch_sel == 3'(i)) IBUS_DO = rdata[i];
  end
endmodule

// File: tb/tb_sh_mtu.sv
// Self-checking bench for sh_mtu. The directed tasks cover the following:
//   - reset
//   - auto-reload
//   - prescaled overflow
//   - byte lanes
//   - collisions
//   - decode
//   - both reset flavours
// A randomized phase is compared every cycle against a register-level
// reference model, which steps once per CE_R edge.
module tb_sh_mtu;
  localparam int          CH   = 4;
  localparam int          W    = 16;
  localparam int          DB   = 13;
  localparam logic [31:0] BASE = 32'hFFFFFC00;

  logic CLK = 0, RST_N = 0, CE_R = 1, CE_F = 0, RES_N = 1;
  logic [31:0] IBUS_A = 0, IBUS_DI = 0, IBUS_DO;
  logic [3:0]  IBUS_BA = 0;
  logic IBUS_WE = 0, IBUS_REQ = 0, IBUS_BUSY, IBUS_ACT;
  logic [CH-1:0]   IRQ;
  logic [8*CH-1:0] VEC;
  int checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  sh_mtu #(.CH(CH), .W(W), .DIV_BITS(DB), .BASE(BASE)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N),
    .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_DO(IBUS_DO), .IBUS_BA(IBUS_BA),
    .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY),
    .IBUS_ACT(IBUS_ACT), .IRQ(IRQ), .VEC(VEC));

  // ---------------- reference model ----------------
  logic [W-1:0] m_tcnt [CH];
  logic [W-1:0] m_tcor [CH];
  logic [31:0]  m_tcr  [CH];
  bit           m_cmf  [CH], m_ovf [CH], m_irq [CH];
  int unsigned  m_div;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] ba);
    for (int b = 0; b < 4; b++) if (ba[b]) old[8*b +: 8] = d[8*b +: 8];
    return old;
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o < 32'd128;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] o;
    int c, r;
    if (!in_win(a)) return 32'h0;
    o = a - BASE;
    c = int'(o[6:4]);
    r = int'(o[3:2]);
    if (c >= CH) return 32'h0;
    case (r)
      0: return 32'(m_tcnt[c]);
      1: return 32'(m_tcor[c]);
      2: return m_tcr[c];
      default: return {30'b0, m_ovf[c], m_cmf[c]};
    endcase
  endfunction

  function automatic void m_clear();
    m_div = 0;
    for (int c = 0; c < CH; c++) begin
      m_tcnt[c] = '0; m_tcor[c] = '1; m_tcr[c] = 0;
      m_cmf[c] = 0; m_ovf[c] = 0; m_irq[c] = 0;
    end
  endfunction

  function automatic void m_step();
    logic [31:0] o;
    logic [W-1:0] nxt;
    bit hit, w, tick, run, scm, sov;
    int wc, wr, k;
    o   = IBUS_A - BASE;
    hit = IBUS_REQ && IBUS_WE && (o < 32'd128);
    wc  = int'(o[6:4]);
    wr  = int'(o[3:2]);
    for (int c = 0; c < CH; c++) begin
      w = hit && (wc == c);
      k = int'(m_tcr[c][4:0]);
      if (k > DB) k = DB;
      tick = ((m_div + 1) % (32'd1 << k)) == 0;
      run  = m_tcr[c][5] && tick && !(w && wr == 2 && IBUS_BA[0] && !IBUS_DI[5]);
      m_irq[c] = (m_cmf[c] && m_tcr[c][7]) || (m_ovf[c] && m_tcr[c][8]);
      nxt = m_tcnt[c]; scm = 0; sov = 0;
      if (run) begin
        nxt = m_tcnt[c] + 1'b1;
        if (m_tcnt[c] == m_tcor[c]) begin
          scm = 1;
          if (m_tcr[c][6]) nxt = '0;
        end
        if (m_tcnt[c] == '1 && !(scm && m_tcr[c][6])) sov = 1;
      end
      if (w) begin
        case (wr)
          0: nxt = W'(merge(32'(m_tcnt[c]), IBUS_DI, IBUS_BA));
          1: m_tcor[c] = W'(merge(32'(m_tcor[c]), IBUS_DI, IBUS_BA));
          2: m_tcr[c] = merge(m_tcr[c], IBUS_DI, IBUS_BA) & 32'h00FF01FF;
          default: begin
            if (IBUS_BA[0] && IBUS_DI[0]) m_cmf[c] = 0;
            if (IBUS_BA[0] && IBUS_DI[1]) m_ovf[c] = 0;
          end
        endcase
      end
      if (scm) m_cmf[c] = 1;
      if (sov) m_ovf[c] = 1;
      m_tcnt[c] = nxt;
    end
    m_div = (m_div + 1) % (32'd1 << DB);
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) m_clear();
    else if (CE_R) begin
      if (!RES_N) m_clear();
      else m_step();
    end
  end

  // ---------------- bus helpers ----------------
  function automatic logic [31:0] ra(input int c, input int r);
    return BASE + 32'(16 * c + 4 * r);
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ba);
    @(negedge CLK);
    IBUS_REQ = 1; IBUS_WE = 1; IBUS_A = a; IBUS_DI = d; IBUS_BA = ba;
    @(posedge CLK); #1;
    IBUS_REQ = 0; IBUS_WE = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic act);
    @(negedge CLK);
    IBUS_REQ = 1; IBUS_WE = 0; IBUS_A = a;
    #1;
    d = IBUS_DO; act = IBUS_ACT;
  endtask

  task automatic idle(input int n);
    IBUS_REQ = 0; IBUS_WE = 0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d; logic a;
    #1;
    checks++; if (IRQ !== '0) begin errors++; $display("FAIL rst_irq got=%h exp=0", IRQ); end
    checks++; if (VEC !== '0) begin errors++; $display("FAIL rst_vec got=%h exp=0", VEC); end
    checks++; if (IBUS_DO !== 32'h0) begin errors++; $display("FAIL rst_do got=%h exp=0", IBUS_DO); end
    checks++; if (IBUS_ACT !== 1'b0 || IBUS_BUSY !== 1'b0) begin errors++; $display("FAIL rst_act_busy got=%b%b exp=00", IBUS_ACT, IBUS_BUSY); end
    @(negedge CLK); RST_N = 1;
    rd(ra(0, 0), d, a);
    checks++; if (d !== 32'h0 || a !== 1'b1) begin errors++; $display("FAIL rst_tcnt got=%h/%b exp=0/1", d, a); end
    rd(ra(3, 1), d, a);
    checks++; if (d !== 32'h0000FFFF) begin errors++; $display("FAIL rst_tcor got=%h exp=0000ffff", d); end
  endtask

  task automatic test_ch0_autoreload();
    logic [31:0] d; logic a;
    logic [31:0] exp [7] = '{0, 1, 2, 3, 4, 5, 0};
    wr(ra(0, 1), 32'd5, 4'hF);
    wr(ra(0, 2), 32'h004200E0, 4'hF);
    for (int i = 0; i < 7; i++) begin
      rd(ra(0, 0), d, a);
      checks++; if (d !== exp[i]) begin errors++; $display("FAIL ch0_seq[%0d] got=%h exp=%h", i, d, exp[i]); end
    end
    checks++; if (IRQ[0] !== 1'b0) begin errors++; $display("FAIL ch0_irq_early got=%b exp=0", IRQ[0]); end
    rd(ra(0, 3), d, a);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL ch0_cmf got=%h exp=1", d); end
    checks++; if (IRQ[0] !== 1'b1) begin errors++; $display("FAIL ch0_irq got=%b exp=1", IRQ[0]); end
    checks++; if (VEC[7:0] !== 8'h42) begin errors++; $display("FAIL ch0_vec got=%h exp=42", VEC[7:0]); end
    wr(ra(0, 2), 32'h004200C0, 4'hF);
    wr(ra(0, 3), 32'h1, 4'h1);
    idle(1);
    checks++; if (IRQ[0] !== 1'b0) begin errors++; $display("FAIL ch0_irq_clr got=%b exp=0", IRQ[0]); end
    rd(ra(0, 3), d, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ch0_tsr_clr got=%h exp=0", d); end
  endtask

  task automatic test_ch1_overflow();
    logic [31:0] d, prev; logic a;
    int last, i;
    bit done;
    wr(ra(1, 0), 32'h0000FFFD, 4'hF);
    wr(ra(1, 2), 32'h00000123, 4'hF);
    prev = 32'h0000FFFD; last = -1; done = 0;
    for (i = 0; i < 48 && !done; i++) begin
      rd(ra(1, 0), d, a);
      checks++; if (d !== model_read(ra(1, 0))) begin errors++; $display("FAIL ch1_model got=%h exp=%h", d, model_read(ra(1, 0))); end
      if (d !== prev) begin
        if (last >= 0) begin
          checks++; if (i - last != 8) begin errors++; $display("FAIL ch1_period got=%0d exp=8", i - last); end
        end
        last = i; prev = d;
        if (d == 32'h0) done = 1;
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL ch1_wrap_timeout got=%h exp=0", d); end
    checks++; if (IRQ[1] !== 1'b0) begin errors++; $display("FAIL ch1_irq_early got=%b exp=0", IRQ[1]); end
    rd(ra(1, 3), d, a);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL ch1_flags got=%h exp=3", d); end
    checks++; if (IRQ[1] !== 1'b1) begin errors++; $display("FAIL ch1_irq got=%b exp=1", IRQ[1]); end
    wr(ra(1, 2), 32'h00000100, 4'hF);
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d; logic a;
    wr(ra(2, 1), 32'h0, 4'hF);
    wr(ra(2, 1), 32'h00001234, 4'b0001);
    rd(ra(2, 1), d, a);
    checks++; if (d !== 32'h00000034 || a !== 1'b1) begin errors++; $display("FAIL lane0 got=%h/%b exp=00000034/1", d, a); end
    wr(ra(2, 1), 32'h0000ABCD, 4'b0010);
    rd(ra(2, 1), d, a);
    checks++; if (d !== 32'h0000AB34) begin errors++; $display("FAIL lane1 got=%h exp=0000ab34", d); end
    wr(ra(2, 2), 32'hFFFFFFFF, 4'b1100);
    rd(ra(2, 2), d, a);
    checks++; if (d !== 32'h00FF0000) begin errors++; $display("FAIL lane_tcr got=%h exp=00ff0000", d); end
    checks++; if (VEC[23:16] !== 8'hFF) begin errors++; $display("FAIL lane_vec got=%h exp=ff", VEC[23:16]); end
    wr(ra(2, 2), 32'h0, 4'hF);
  endtask

  task automatic test_collision();
    logic [31:0] d, d2; logic a;
    bit found;
    wr(ra(3, 1), 32'h105, 4'hF);
    wr(ra(3, 2), 32'h20, 4'hF);
    wr(ra(3, 0), 32'h100, 4'hF);
    rd(ra(3, 0), d, a);
    checks++; if (d !== 32'h100) begin errors++; $display("FAIL coll_tcnt got=%h exp=00000100", d); end
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      rd(ra(3, 0), d, a);
      if (d == 32'h104) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL coll_poll_timeout got=%h exp=00000104", d); end
    wr(ra(3, 3), 32'h1, 4'h1);
    rd(ra(3, 3), d, a);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL coll_cmf got=%h exp=1", d); end
    wr(ra(3, 2), 32'h0, 4'hF);
    rd(ra(3, 0), d, a);
    idle(3);
    rd(ra(3, 0), d2, a);
    checks++; if (d2 !== d) begin errors++; $display("FAIL coll_stop got=%h exp=%h", d2, d); end
  endtask

  task automatic test_decode();
    logic [31:0] d; logic a;
    rd(BASE + 32'h40, d, a);
    checks++; if (a !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL dec_ch4 got=%h/%b exp=0/1", d, a); end
    wr(BASE + 32'h44, 32'h1, 4'hF);
    rd(ra(0, 1), d, a);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL dec_alias got=%h exp=5", d); end
    rd(BASE - 32'h4, d, a);
    checks++; if (a !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL dec_below got=%h/%b exp=0/0", d, a); end
    rd(BASE + 32'h80, d, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL dec_above got=%b exp=0", a); end
  endtask

  task automatic test_random();
    logic [31:0] exp_do, d; logic a;
    bit exp_act;
    for (int n = 0; n < 500; n++) begin
      @(negedge CLK);
      CE_R     = ($urandom_range(0, 9) != 0);
      RES_N    = ($urandom_range(0, 149) != 0);
      IBUS_REQ = ($urandom_range(0, 3) != 0);
      IBUS_WE  = ($urandom_range(0, 9) < 3);
      IBUS_A   = BASE + 32'($urandom_range(0, 16'h8F)) - 32'd8;
      IBUS_BA  = 4'($urandom_range(0, 15));
      IBUS_DI  = $urandom;
      if ($urandom_range(0, 3) == 0) IBUS_DI = 32'h0000FFF0 | 32'($urandom_range(0, 15));
      #1;
      exp_act = IBUS_REQ && in_win(IBUS_A);
      exp_do  = (IBUS_REQ && !IBUS_WE) ? model_read(IBUS_A) : 32'h0;
      checks++; if (IBUS_ACT !== exp_act) begin errors++; $display("FAIL rnd_act[%0d] got=%b exp=%b", n, IBUS_ACT, exp_act); end
      checks++; if (IBUS_DO !== exp_do) begin errors++; $display("FAIL rnd_do[%0d] got=%h exp=%h", n, IBUS_DO, exp_do); end
      for (int c = 0; c < CH; c++) begin
        checks++; if (IRQ[c] !== m_irq[c]) begin errors++; $display("FAIL rnd_irq[%0d] ch%0d got=%b exp=%b", n, c, IRQ[c], m_irq[c]); end
        checks++; if (VEC[8*c +: 8] !== m_tcr[c][23:16]) begin errors++; $display("FAIL rnd_vec[%0d] ch%0d got=%h exp=%h", n, c, VEC[8*c +: 8], m_tcr[c][23:16]); end
      end
    end
    @(negedge CLK);
    CE_R = 1; RES_N = 1; IBUS_REQ = 0; IBUS_WE = 0;
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < 4; r++) begin
        rd(ra(c, r), d, a);
        checks++; if (d !== model_read(ra(c, r))) begin errors++; $display("FAIL rnd_final ch%0d r%0d got=%h exp=%h", c, r, d, model_read(ra(c, r))); end
      end
  endtask

  task automatic arm_ch0();
    wr(ra(0, 1), 32'h2, 4'hF);
    wr(ra(0, 2), 32'h004200E0, 4'hF);
    idle(8);
    checks++; if (IRQ[0] !== 1'b1) begin errors++; $display("FAIL arm_irq got=%b exp=1", IRQ[0]); end
  endtask

  task automatic test_res_n();
    logic [31:0] d; logic a;
    arm_ch0();
    @(negedge CLK); RES_N = 0;
    @(posedge CLK); #1; RES_N = 1;
    checks++; if (IRQ !== '0 || VEC !== '0) begin errors++; $display("FAIL resn_out got=%h/%h exp=0/0", IRQ, VEC); end
    rd(ra(0, 1), d, a);
    checks++; if (d !== 32'h0000FFFF) begin errors++; $display("FAIL resn_tcor got=%h exp=0000ffff", d); end
    idle(4);
    rd(ra(0, 0), d, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL resn_stopped got=%h exp=0", d); end
  endtask

  task automatic test_rst_midrun();
    logic [31:0] d; logic a;
    arm_ch0();
    @(negedge CLK); #2; RST_N = 0; #1;
    checks++; if (IRQ !== '0 || VEC !== '0) begin errors++; $display("FAIL rstn_out got=%h/%h exp=0/0", IRQ, VEC); end
    @(negedge CLK); RST_N = 1;
    rd(ra(0, 0), d, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rstn_tcnt got=%h exp=0", d); end
    rd(ra(0, 1), d, a);
    checks++; if (d !== 32'h0000FFFF) begin errors++; $display("FAIL rstn_tcor got=%h exp=0000ffff", d); end
  endtask

  initial begin
    test_reset();
    test_ch0_autoreload();
    test_ch1_overflow();
    test_byte_lanes();
    test_collision();
    test_decode();
    test_random();
    test_res_n();
    test_rst_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
